game_timer_ctrl: RTL and testbench
==================================

Name: game_timer_ctrl

Overview:
Control stage directly upstream of the two-digit countdown display timer.
- Conditions the raw start and pause keys: synchronise, debounce, then detect the press edge.
- Runs the IDLE/RUNNING/PAUSED/FINISHED game FSM.
- Prescales clk into the one_second_pulse that decrements the countdown.
- Issues timer_clear to restart the countdown, and consumes game_finished back from the countdown.

Parameters:
TICK_DIV, 50000000, clk cycles per one_second_pulse period; must be >= 2
DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples required before a debounced key level changes; must be >= 1

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
start_n  input  1  raw start key, active-low, asynchronous to clk
pause_n  input  1  raw pause key, active-low, asynchronous to clk
game_finished  input  1  countdown reached 00 (level, from countdown timer)
one_second_pulse  output  1  single-cycle tick to countdown timer
timer_clear  output  1  single-cycle reset request to countdown timer (drives its rst)
state  output  2  0=IDLE, 1=RUNNING, 2=PAUSED, 3=FINISHED
running  output  1  high iff state==RUNNING

Behaviour:
Reset, asynchronous:
- state=IDLE; one_second_pulse=0; timer_clear=0; running=0; prescaler=0.
- Both synchroniser stages=1; debounced levels=1; debounce counters=0.

Key conditioning, identical per key:
- Two-FF synchroniser.
- Debounce counter:
  - Counter clears whenever the synchronised sample equals the debounced level.
  - Otherwise it increments.
  - When it reaches DEBOUNCE_CYCLES-1, the debounced level takes the sample and the counter clears.
- Press event: one-cycle strobe when the debounced level goes 1->0. Release produces no event.
- Worst-case latency from a raw edge to the strobe: 2 + DEBOUNCE_CYCLES cycles.

Prescaler:
- Width $clog2(TICK_DIV), counting 0..TICK_DIV-1.
- Increments only in RUNNING cycles that take no transition.
- At TICK_DIV-1 it wraps to 0, and one_second_pulse is registered high for exactly the next cycle.
- Holds its value in PAUSED. Forced to 0 on any restart.
- one_second_pulse is never high outside RUNNING-driven wraps.

Restart:
- Entering RUNNING via start_press, from any state, sets prescaler=0.
- timer_clear is registered high for exactly one cycle: the first cycle in RUNNING.
- The first one_second_pulse is high in cycle TICK_DIV after timer_clear's cycle.

FSM, evaluated each clock edge; priority per state as listed:
- IDLE:
  - start_press -> RUNNING with restart.
  - pause_press is ignored.
  - game_finished is ignored.
- RUNNING:
  - game_finished (ignored in the cycle timer_clear is high) -> FINISHED.
  - Else start_press -> RUNNING with restart.
  - Else pause_press -> PAUSED; the prescaler does not increment on that edge, and no pulse is issued even if the count was at TICK_DIV-1.
  - Else count.
- PAUSED:
  - game_finished -> FINISHED.
  - Else start_press -> RUNNING with restart.
  - Else pause_press -> RUNNING, resuming from the held prescaler value with no timer_clear.
  - Else hold.
- FINISHED:
  - start_press -> RUNNING with restart.
  - pause_press is ignored.
  - No pulses are issued.

Simultaneous events:
- game_finished beats a wrap: no pulse on that edge.
- start beats pause when both strobe on the same edge.

Other rules:
- running and state are combinational decodes of the state register.
- Reset mid-operation: outputs return to their reset values immediately; the debounce state restarts, so a held key does not generate a press until it is released, debounced high, then pressed again.

Test Plan:
1. TICK_DIV=10, DEBOUNCE_CYCLES=4. Hold start_n low for 8 cycles -> a single start strobe; state IDLE->RUNNING; timer_clear high for 1 cycle; one_second_pulse high in cycles 10, 20, 30 after timer_clear, each 1 cycle wide.
2. Glitch start_n low for 2 cycles, 3 times -> no strobe; state stays IDLE; timer_clear is never asserted.
3. Running with the prescaler at 6: pause press -> PAUSED, prescaler held at 6, no pulse for 50 cycles. Second pause press -> RUNNING with no timer_clear; next pulse 4 cycles after resume.
4. Press pause on the exact edge the prescaler is at 9 -> PAUSED, no pulse. After resume, the pulse arrives 1 cycle later (prescaler 9->0).
5. Drive game_finished=1 while RUNNING -> FINISHED next edge; no further pulses; pause press ignored. Start press -> RUNNING plus a timer_clear pulse. With game_finished dropped one cycle after timer_clear, the state remains RUNNING.
6. Assert rst mid-RUNNING with start_n held low -> state=IDLE and outputs 0 immediately. After rst release, no start until start_n goes high, is debounced, and is pressed again.

Source files
------------

// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: key conditioning, game FSM and one-second prescaler feeding the countdown display.
// Latency: raw key edge to press strobe is at most 2+DEBOUNCE_CYCLES cycles; FSM reacts on the following edge.
// Backpressure: none; inputs are sampled every cycle and outputs are single-cycle strobes or levels.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   start_n, pause_n  raw active-low keys, asynchronous to clk
//   game_finished     level from the countdown, high once it shows 00
//   one_second_pulse  one-cycle tick that decrements the countdown
//   timer_clear       one-cycle restart request (drives the countdown reset)
//   state             0=IDLE 1=RUNNING 2=PAUSED 3=FINISHED
//   running           high iff state is RUNNING

// game_timer_key_cond: two-FF synchroniser, debouncer and press-edge detector for one key.
// Latency: press strobe is registered 2+DEBOUNCE_CYCLES cycles after a raw falling edge (worst case).
// Backpressure: none; the strobe is a one-cycle pulse and is never held.
module game_timer_key_cond #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          deb_lvl;
  logic [CW-1:0] deb_cnt;
  logic [1:0]    prime;
  logic          armed;
  logic [CW-1:0] arm_cnt;
  logic          deb_done;

  // The debounced level flips on this edge: the sample has disagreed with it
  // for DEBOUNCE_CYCLES consecutive cycles, including this one.
  assign deb_done = (sync_q2 != deb_lvl) && (deb_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      deb_lvl <= 1'b1;
      deb_cnt <= '0;
      prime   <= 2'b00;
      armed   <= 1'b0;
      arm_cnt <= '0;
      press   <= 1'b0;
    end else begin
      sync_q1 <= key_n;
      sync_q2 <= sync_q1;

      if (sync_q2 == deb_lvl) begin
        deb_cnt <= '0;
      end else if (deb_cnt == CNT_LAST) begin
        deb_lvl <= sync_q2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + CW'(1);
      end

      // Only a 1->0 change of the debounced level is an event; deb_done with
      // the old level at 1 implies the new sample is 0.
      press <= deb_done && deb_lvl && armed;

      // The synchroniser comes out of reset holding 1, which says nothing
      // about the real key. prime marks when sync_q2 carries a genuine
      // sample. Presses stay masked until the key has really been seen
      // released for DEBOUNCE_CYCLES cycles, so a key held through reset
      // cannot fire as soon as reset lifts.
      prime <= {prime[0], 1'b1};
      if (!armed) begin
        if (prime[1] && sync_q2) begin
          if (arm_cnt == CNT_LAST) begin
            armed <= 1'b1;
          end else begin
            arm_cnt <= arm_cnt + CW'(1);
          end
        end else begin
          arm_cnt <= '0;
        end
      end
    end
  end

endmodule

// game_timer_ctrl: top level; two key conditioners, the game FSM and the prescaler.
// Latency: timer_clear and one_second_pulse are registered one edge after the causing condition.
// Backpressure: none; game_finished is a level consumed every cycle.
module game_timer_ctrl #(
  parameter int TICK_DIV        = 50000000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_n,
  input  logic       pause_n,
  input  logic       game_finished,
  output logic       one_second_pulse,
  output logic       timer_clear,
  output logic [1:0] state,
  output logic       running
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_PAUSED   = 2'd2,
    ST_FINISHED = 2'd3
  } state_t;

  state_t        state_q;
  logic [PW-1:0] prescaler;
  logic          pulse_q;
  logic          clear_q;
  logic          start_press;
  logic          pause_press;

  game_timer_key_cond #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_start_key (
    .clk  (clk),
    .rst  (rst),
    .key_n(start_n),
    .press(start_press)
  );

  game_timer_key_cond #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_pause_key (
    .clk  (clk),
    .rst  (rst),
    .key_n(pause_n),
    .press(pause_press)
  );

  assign state            = state_q;
  assign running          = (state_q == ST_RUNNING);
  assign one_second_pulse = pulse_q;
  assign timer_clear      = clear_q;

  // A restart (start press from any state) always lands in RUNNING with the
  // prescaler at zero and a one-cycle clear, so the first tick follows the
  // clear by exactly TICK_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      prescaler <= '0;
      pulse_q   <= 1'b0;
      clear_q   <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      clear_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_press) begin
            state_q   <= ST_RUNNING;
            prescaler <= '0;
            clear_q   <= 1'b1;
          end
        end

        ST_RUNNING: begin
          // game_finished is stale while the countdown is being cleared.
          if (game_finished && !clear_q) begin
            state_q <= ST_FINISHED;
          end else if (start_press) begin
            prescaler <= '0;
            clear_q   <= 1'b1;
          end else if (pause_press) begin
            // Prescaler frozen as-is; a pending wrap is deferred to resume.
            state_q <= ST_PAUSED;
          end else if (prescaler == PRESC_LAST) begin
            prescaler <= '0;
            pulse_q   <= 1'b1;
          end else begin
            prescaler <= prescaler + PW'(1);
          end
        end

        ST_PAUSED: begin
          if (game_finished) begin
            state_q <= ST_FINISHED;
          end else if (start_press) begin
            state_q   <= ST_RUNNING;
            prescaler <= '0;
            clear_q   <= 1'b1;
          end else if (pause_press) begin
            // Resume: keep the partial second already counted.
            state_q <= ST_RUNNING;
          end
        end

        ST_FINISHED: begin
          if (start_press) begin
            state_q   <= ST_RUNNING;
            prescaler <= '0;
            clear_q   <= 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_timer_ctrl.sv
// tb_game_timer_ctrl: directed scenarios followed by random key/finish traffic,
// every cycle compared against a behavioural model of the controller.
// Ports of the DUT are all driven at the falling edge and sampled at the falling edge.
module tb_game_timer_ctrl;

  localparam int T = 10;
  localparam int D = 4;
  localparam int MASK_ALL = (1 << D) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_n;
  logic       pause_n;
  logic       game_finished;
  logic       one_second_pulse;
  logic       timer_clear;
  logic [1:0] state;
  logic       running;

  always #5 clk = ~clk;

  game_timer_ctrl #(
    .TICK_DIV       (T),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start_n         (start_n),
    .pause_n         (pause_n),
    .game_finished   (game_finished),
    .one_second_pulse(one_second_pulse),
    .timer_clear     (timer_clear),
    .state           (state),
    .running         (running)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int m_state;
  int m_presc;
  bit m_tc;
  bit m_pulse;
  bit m_press [2];
  bit m_d1    [2];
  bit m_d2    [2];
  bit m_deb   [2];
  bit m_armed [2];
  int m_mask  [2];
  int m_arm_run [2];
  int edge_n;

  // ---------------- observation log ----------------
  int cyc = 0;
  int tc_count = 0;
  int tc_cyc = -1;
  int resume_cyc = -1;
  int prev_state = 0;
  int pulse_q [$];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_presc = 0;
    m_tc    = 1'b0;
    m_pulse = 1'b0;
    edge_n  = 0;
    for (int k = 0; k < 2; k++) begin
      m_press[k]   = 1'b0;
      m_d1[k]      = 1'b1;
      m_d2[k]      = 1'b1;
      m_deb[k]     = 1'b1;
      m_armed[k]   = 1'b0;
      m_mask[k]    = MASK_ALL;
      m_arm_run[k] = 0;
    end
  endtask

  // One clock edge of the model, using the inputs as they stand before the edge.
  task automatic model_edge();
    bit       sp, pp, n_tc, n_pulse, smp, flip;
    bit [1:0] raw;
    if (rst) begin
      model_reset();
      return;
    end
    edge_n++;
    sp = m_press[0];
    pp = m_press[1];
    n_tc = 1'b0;
    n_pulse = 1'b0;
    case (m_state)
      0: if (sp) begin m_state = 1; m_presc = 0; n_tc = 1'b1; end
      1: begin
        if (game_finished && !m_tc) m_state = 3;
        else if (sp) begin m_presc = 0; n_tc = 1'b1; end
        else if (pp) m_state = 2;
        else begin
          n_pulse = (m_presc == T - 1);
          m_presc = (m_presc + 1) % T;
        end
      end
      2: begin
        if (game_finished) m_state = 3;
        else if (sp) begin m_state = 1; m_presc = 0; n_tc = 1'b1; end
        else if (pp) m_state = 1;
      end
      default: if (sp) begin m_state = 1; m_presc = 0; n_tc = 1'b1; end
    endcase
    m_tc = n_tc;
    m_pulse = n_pulse;

    // Keys: the debouncer sees the raw level two edges late; its level flips
    // once the last D samples all disagree with it.
    raw = {pause_n, start_n};
    for (int k = 0; k < 2; k++) begin
      smp = m_d2[k];
      m_d2[k] = m_d1[k];
      m_d1[k] = raw[k];
      m_mask[k] = ((m_mask[k] << 1) | int'(smp)) & MASK_ALL;
      flip = m_deb[k] ? (m_mask[k] == 0) : (m_mask[k] == MASK_ALL);
      m_press[k] = flip && m_deb[k] && m_armed[k];
      if (flip) m_deb[k] = !m_deb[k];
      if (!m_armed[k]) begin
        if (edge_n >= 3 && smp) begin
          m_arm_run[k]++;
          if (m_arm_run[k] >= D) m_armed[k] = 1'b1;
        end else begin
          m_arm_run[k] = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    chk("state", int'(state), m_state);
    chk("running", int'(running), int'(m_state == 1));
    chk("timer_clear", int'(timer_clear), int'(m_tc));
    chk("one_second_pulse", int'(one_second_pulse), int'(m_pulse));
    if (timer_clear === 1'b1) begin
      tc_count++;
      tc_cyc = cyc;
    end
    if (one_second_pulse === 1'b1) pulse_q.push_back(cyc);
    if (prev_state == 2 && state == 2'd1) resume_cyc = cyc;
    prev_state = int'(state);
  endtask

  initial begin
    int t0;
    int n0;
    int hold [2];
    bit lv;

    rst = 1'b1;
    start_n = 1'b1;
    pause_n = 1'b1;
    game_finished = 1'b0;
    model_reset();
    #2;
    chk("reset_state", int'(state), 0);
    chk("reset_running", int'(running), 0);
    chk("reset_timer_clear", int'(timer_clear), 0);
    chk("reset_pulse", int'(one_second_pulse), 0);
    repeat (3) step();
    rst = 1'b0;
    repeat (10) step();

    // Short glitches never survive the debouncer.
    repeat (3) begin
      start_n = 1'b0;
      repeat (2) step();
      start_n = 1'b1;
      repeat (4) step();
    end
    repeat (8) step();
    chk("glitch_idle", int'(state), 0);
    chk("glitch_no_clear", tc_count, 0);

    // Start press: one clear, ticks every T cycles after it.
    t0 = tc_count;
    pulse_q.delete();
    start_n = 1'b0;
    repeat (8) step();
    start_n = 1'b1;
    for (int i = 0; i < 60 && pulse_q.size() < 3; i++) step();
    chk("start_single_clear", tc_count - t0, 1);
    chk("start_running", int'(state), 1);
    for (int i = 0; i < 3; i++)
      chk("pulse_gap", (pulse_q.size() > i) ? pulse_q[i] - tc_cyc : -1, T * (i + 1));

    // Pause taking effect with the prescaler at 6 (press lands 7 edges after the key drop).
    n0 = pulse_q.size();
    pause_n = 1'b0;
    repeat (8) step();
    pause_n = 1'b1;
    chk("pause_state", int'(state), 2);
    repeat (42) step();
    chk("paused_no_pulse", pulse_q.size() - n0, 0);
    chk("paused_hold", int'(state), 2);
    resume_cyc = -1;
    pause_n = 1'b0;
    repeat (8) step();
    pause_n = 1'b1;
    for (int i = 0; i < 30 && pulse_q.size() == n0; i++) step();
    chk("resume_pulse_delay", (pulse_q.size() > n0) ? pulse_q[n0] - resume_cyc : -1, 4);
    chk("resume_no_clear", tc_count - t0, 1);

    // Pause on the exact wrap edge (prescaler at 9).
    repeat (3) step();
    n0 = pulse_q.size();
    pause_n = 1'b0;
    repeat (8) step();
    pause_n = 1'b1;
    chk("wrap_pause_state", int'(state), 2);
    repeat (10) step();
    chk("wrap_pause_no_pulse", pulse_q.size() - n0, 0);
    resume_cyc = -1;
    pause_n = 1'b0;
    repeat (8) step();
    pause_n = 1'b1;
    for (int i = 0; i < 30 && pulse_q.size() == n0; i++) step();
    chk("wrap_resume_delay", (pulse_q.size() > n0) ? pulse_q[n0] - resume_cyc : -1, 1);

    // game_finished ends the game; pause ignored; start restarts despite stale finish.
    game_finished = 1'b1;
    step();
    chk("finish_next_edge", int'(state), 3);
    n0 = pulse_q.size();
    pause_n = 1'b0;
    repeat (8) step();
    pause_n = 1'b1;
    repeat (8) step();
    chk("finish_pause_ignored", int'(state), 3);
    chk("finish_no_pulse", pulse_q.size() - n0, 0);
    t0 = tc_count;
    start_n = 1'b0;
    for (int i = 0; i < 20 && tc_count == t0; i++) step();
    chk("finish_restart_clear", tc_count - t0, 1);
    step();
    game_finished = 1'b0;
    start_n = 1'b1;
    repeat (5) step();
    chk("run_after_clear", int'(state), 1);

    // Reset mid-run with start held: no start until released and pressed again.
    repeat (4) step();
    t0 = tc_count;
    start_n = 1'b0;
    for (int i = 0; i < 20 && tc_count == t0; i++) step();
    repeat (3) step();
    chk("pre_reset_running", int'(state), 1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_state", int'(state), 0);
    chk("midrst_running", int'(running), 0);
    chk("midrst_timer_clear", int'(timer_clear), 0);
    chk("midrst_pulse", int'(one_second_pulse), 0);
    repeat (2) step();
    rst = 1'b0;
    t0 = tc_count;
    repeat (30) step();
    chk("held_no_start", tc_count - t0, 0);
    chk("held_idle", int'(state), 0);
    start_n = 1'b1;
    repeat (10) step();
    start_n = 1'b0;
    repeat (8) step();
    start_n = 1'b1;
    chk("repress_running", int'(state), 1);
    chk("repress_clear", tc_count - t0, 1);

    // Random traffic against the model.
    hold[0] = 0;
    hold[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (hold[k] == 0) begin
          lv = ($urandom_range(0, 9) < 4) ? 1'b0 : 1'b1;
          hold[k] = $urandom_range(1, 15);
          if (k == 0) start_n = lv;
          else pause_n = lv;
        end
        hold[k]--;
      end
      if ($urandom_range(0, 39) == 0) game_finished = !game_finished;
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
